// File: rtl/port_ingress_buffer.sv
// port_ingress_buffer: filtered first-word-fall-through packet FIFO feeding one switch port
//   clk, rst                            clock and synchronous active-high reset
//   in_valid/in_ready                   host-side accept handshake (in_ready = not full)
//   in_source/in_target/in_data         offered packet: one-hot source, target mask, payload
//   out_valid/out_ready                 switch-side handshake for head-of-FIFO packet
//   out_source/out_target/out_data      head packet fields, zero when empty
//   level                               stored packet count
//   drop_count                          saturating count of filtered packets
module port_ingress_buffer #(
   parameter int DEPTH = 4,
   parameter int PORT_ID = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [3:0]                 in_source,
   input  logic [3:0]                 in_target,
   input  logic [7:0]                 in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [3:0]                 out_source,
   output logic [3:0]                 out_target,
   output logic [7:0]                 out_data,
   output logic [$clog2(DEPTH):0]     level,
   output logic [7:0]                 drop_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [3:0]    eff_target;
   logic          one_hot, accept, keep, drop, pop;
   // the own-port bit is cleared so a packet never loops back to its ingress
   always_comb begin
      eff_target = in_target & ~(4'b0001 << PORT_ID);
      one_hot    = (in_source != 4'b0000) && ((in_source & (in_source - 4'b0001)) == 4'b0000);
      in_ready   = level < LW'(DEPTH);
      accept     = in_valid && in_ready;
      keep       = accept && one_hot && (eff_target != 4'b0000);
      drop       = accept && !keep;
      out_valid  = level != '0;
      pop        = out_valid && out_ready;
      {out_source, out_target, out_data} = out_valid ? mem[rp] : 16'h0000;
   end
   always_ff @(posedge clk) begin
      if (keep && !rst) mem[wp] <= {in_source, eff_target, in_data};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wp         <= '0;
         rp         <= '0;
         level      <= '0;
         drop_count <= '0;
      end else begin
         if (keep) wp <= wp + AW'(1);
         if (pop) rp <= rp + AW'(1);
         level <= level + LW'(keep) - LW'(pop);
         if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
   end
endmodule

// File: tb/tb_port_ingress_buffer.sv
// tb_port_ingress_buffer: vector table, corner sequences and random traffic against a queue model
module tb_port_ingress_buffer;
   localparam int DEPTH = 4;
   localparam int PORT_ID = 0;
   logic       clk = 0, rst = 0, in_valid = 0, out_ready = 0;
   logic [3:0] in_source = 0, in_target = 0, out_source, out_target;
   logic [7:0] in_data = 0, out_data, drop_count;
   logic       in_ready, out_valid;
   logic [2:0] level;
   int         n_chk = 0, n_fail = 0;
   logic [15:0] q[$];
   int         m_drop = 0;

   port_ingress_buffer #(.DEPTH(DEPTH), .PORT_ID(PORT_ID)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_source(in_source), .in_target(in_target), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_source(out_source),
      .out_target(out_target), .out_data(out_data), .level(level), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       r, v;
      logic [3:0] s, t;
      logic [7:0] d;
      logic       o, er, ev;
      logic [3:0] es, et;
      logic [7:0] ed;
      logic [2:0] el;
      logic [7:0] edr;
   } vec_t;
   vec_t vt[$];

   function automatic vec_t mk(logic r, logic v, logic [3:0] s, logic [3:0] t, logic [7:0] d, logic o,
                               logic er, logic ev, logic [3:0] es, logic [3:0] et, logic [7:0] ed,
                               logic [2:0] el, logic [7:0] edr);
      vec_t x;
      x = {r, v, s, t, d, o, er, ev, es, et, ed, el, edr};
      return x;
   endfunction

   task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask

   task automatic model_check();
      logic [15:0] h;
      h = (q.size() != 0) ? q[0] : 16'h0000;
      chk("m_in_ready", 16'(in_ready), 16'(q.size() < DEPTH));
      chk("m_out_valid", 16'(out_valid), 16'(q.size() != 0));
      chk("m_level", 16'(level), 16'(q.size()));
      chk("m_drop", 16'(drop_count), 16'(m_drop));
      chk("m_head", {out_source, out_target, out_data}, h);
   endtask

   task automatic cycle(input logic r, input logic v, input logic [3:0] s, input logic [3:0] t,
                        input logic [7:0] d, input logic o);
      logic acc, pp;
      logic [3:0] eff;
      rst = r; in_valid = v; in_source = s; in_target = t; in_data = d; out_ready = o;
      @(posedge clk);
      if (r) begin
         q.delete();
         m_drop = 0;
      end else begin
         acc = v && (q.size() < DEPTH);
         pp = (q.size() != 0) && o;
         eff = t & ~(4'b0001 << PORT_ID);
         if (pp) void'(q.pop_front());
         if (acc && $countones(s) == 1 && eff != 0) q.push_back({s, eff, d});
         else if (acc && m_drop < 255) m_drop++;
      end
      @(negedge clk);
      model_check();
   endtask

   initial begin
      int k;
      logic taken, vv;
      logic [7:0] exp_d[$];
      vt.push_back(mk(1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0));
      vt.push_back(mk(0, 1, 1, 2, 8'h51, 1, 1, 1, 1, 2, 8'h51, 1, 0));
      vt.push_back(mk(0, 0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 0, 0));
      vt.push_back(mk(0, 1, 1, 4'hF, 8'hB1, 0, 1, 1, 1, 4'hE, 8'hB1, 1, 0));
      vt.push_back(mk(0, 0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 0, 0));
      vt.push_back(mk(0, 1, 1, 1, 8'hC0, 0, 1, 0, 0, 0, 8'h00, 0, 1));
      vt.push_back(mk(0, 1, 3, 2, 8'h01, 0, 1, 0, 0, 0, 8'h00, 0, 2));
      vt.push_back(mk(0, 1, 0, 2, 8'h02, 0, 1, 0, 0, 0, 8'h00, 0, 3));
      vt.push_back(mk(0, 1, 2, 4, 8'h10, 0, 1, 1, 2, 4, 8'h10, 1, 3));
      vt.push_back(mk(0, 1, 2, 4, 8'h11, 0, 1, 1, 2, 4, 8'h10, 2, 3));
      vt.push_back(mk(0, 1, 2, 4, 8'h12, 0, 1, 1, 2, 4, 8'h10, 3, 3));
      vt.push_back(mk(1, 1, 2, 4, 8'h13, 1, 1, 0, 0, 0, 8'h00, 0, 0));
      vt.push_back(mk(0, 1, 8, 8, 8'h20, 0, 1, 1, 8, 8, 8'h20, 1, 0));
      vt.push_back(mk(0, 0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 0, 0));
      @(negedge clk);
      foreach (vt[i]) begin
         cycle(vt[i].r, vt[i].v, vt[i].s, vt[i].t, vt[i].d, vt[i].o);
         chk($sformatf("v%0d_ready", i), 16'(in_ready), 16'(vt[i].er));
         chk($sformatf("v%0d_valid", i), 16'(out_valid), 16'(vt[i].ev));
         chk($sformatf("v%0d_fields", i), {out_source, out_target, out_data}, {vt[i].es, vt[i].et, vt[i].ed});
         chk($sformatf("v%0d_level", i), 16'(level), 16'(vt[i].el));
         chk($sformatf("v%0d_drop", i), 16'(drop_count), 16'(vt[i].edr));
      end
      // fill past full with the switch stalled, then drain in order
      cycle(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 1, 1, 2, 8'hE0 + 8'(i), 0);
         if (i == 3) begin
            chk("full_ready", 16'(in_ready), 16'd0);
            chk("full_level", 16'(level), 16'd4);
         end
      end
      chk("full_head", 16'(out_data), 16'hE0);
      taken = 0;
      k = 0;
      for (int c = 0; c < 20 && k < 5; c++) begin
         if (out_valid) begin
            chk("drain_order", 16'(out_data), 16'(8'hE0 + 8'(k)));
            k++;
         end
         vv = !taken;
         if (vv && in_ready) taken = 1;
         cycle(0, vv, 1, 2, 8'hE4, 1);
      end
      chk("drain_count", 16'(k), 16'd5);
      chk("drain_empty", 16'(out_valid), 16'd0);
      // streaming at level 2 across pointer wrap
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 1, 4, 2, 8'hA0, 0);
      cycle(0, 1, 4, 2, 8'hA1, 0);
      exp_d = '{8'hA0, 8'hA1, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      k = 0;
      for (int i = 0; i < 8; i++) begin
         chk("stream_order", 16'(out_data), 16'(exp_d[k]));
         k++;
         cycle(0, 1, 4, 2, 8'(i), 1);
         chk("stream_level", 16'(level), 16'd2);
      end
      for (int i = 0; i < 2; i++) begin
         chk("stream_tail", 16'(out_data), 16'(exp_d[k]));
         k++;
         cycle(0, 0, 0, 0, 0, 1);
      end
      chk("stream_empty", 16'(level), 16'd0);
      // drop counter saturation
      for (int i = 0; i < 300; i++) cycle(0, 1, 4'b0011, 2, 8'(i), 0);
      chk("sat_drop", 16'(drop_count), 16'd255);
      chk("sat_level", 16'(level), 16'd0);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] s;
         s = ($urandom_range(0, 7) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
         cycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, s, 4'($urandom), 8'($urandom),
               $urandom_range(0, 2) != 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
